// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: captures a 4-digit packed BCD word on the rising edge of rdy
//   and time-multiplexes it onto a common-anode 7-segment display.
//   Each digit slot lasts REFRESH_DIV cycles; the last cycle is all-off.
// Ports: clk, rst (sync, active-high), rdy (level, captured on 0->1),
//   bcd_d_in[15:0] (digit 0 in [3:0]), an[3:0] (active-low digit enables),
//   seg[6:0] (active-low {g,f,e,d,c,b,a}), bcd_err (captured word has a nibble > 9).
// Optional macro LEADING_ZERO_BLANK_EN: blank leading zero digits 3..1.
module bcd_seg_scan #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [15:0] bcd_d_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        bcd_err
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {DIG0 = 2'd0, DIG1 = 2'd1, DIG2 = 2'd2, DIG3 = 2'd3} scan_t;

  scan_t         state, state_nxt;
  logic [CW-1:0] cnt;
  logic [15:0]   disp_q;
  logic          rdy_q;
  logic          cap;
  logic          slot_end;
  logic [3:0]    nib;
  logic          lz_blank;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;

  // Active-low hex decode; anything outside 0..9 renders as a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  function automatic logic has_bad_nibble(input logic [15:0] w);
    return (w[3:0] > 4'd9) || (w[7:4] > 4'd9) ||
           (w[11:8] > 4'd9) || (w[15:12] > 4'd9);
  endfunction

  // Holding rdy high produces a single capture.
  assign cap      = rdy & ~rdy_q;
  assign slot_end = (cnt == CNT_LAST);

  // Scan ring: next-state and registered-output values.
  always_comb begin
    state_nxt = state;
    nib       = 4'd0;
    lz_blank  = 1'b0;
    an_nxt    = 4'hF;
    seg_nxt   = 7'h7F;

    if (slot_end) begin
      case (state)
        DIG0:    state_nxt = DIG1;
        DIG1:    state_nxt = DIG2;
        DIG2:    state_nxt = DIG3;
        default: state_nxt = DIG0;
      endcase
    end

    case (state)
      DIG0: begin nib = disp_q[3:0];   an_nxt = 4'b1110; end
      DIG1: begin nib = disp_q[7:4];   an_nxt = 4'b1101; end
      DIG2: begin nib = disp_q[11:8];  an_nxt = 4'b1011; end
      default: begin nib = disp_q[15:12]; an_nxt = 4'b0111; end
    endcase

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blanked when it and every more significant digit are zero;
    // digit 0 always shows so a zero value is still visible.
    case (state)
      DIG1:    lz_blank = (disp_q[15:4] == 12'd0);
      DIG2:    lz_blank = (disp_q[15:8] == 8'd0);
      DIG3:    lz_blank = (disp_q[15:12] == 4'd0);
      default: lz_blank = 1'b0;
    endcase
`else
    lz_blank = 1'b0;
`endif

    if (slot_end) begin
      an_nxt  = 4'hF;
      seg_nxt = 7'h7F;
    end else if (lz_blank) begin
      seg_nxt = 7'h7F;
    end else begin
      seg_nxt = decode(nib);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIG0;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs sample disp_q before any capture on this edge, so a new word
  // appears no earlier than the following output update.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      disp_q  <= 16'h0000;
      rdy_q   <= 1'b0;
      an      <= 4'hF;
      seg     <= 7'h7F;
      bcd_err <= 1'b0;
    end else begin
      rdy_q <= rdy;
      cnt   <= slot_end ? '0 : cnt + 1'b1;
      an    <= an_nxt;
      seg   <= seg_nxt;
      if (cap) begin
        disp_q  <= bcd_d_in;
        bcd_err <= has_bad_nibble(bcd_d_in);
      end
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
module tb_bcd_seg_scan;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic [15:0] bcd_d_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        bcd_err;

  int n_vec = 0;
  int n_bad = 0;

  bcd_seg_scan #(.REFRESH_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .bcd_d_in (bcd_d_in),
    .an       (an),
    .seg      (seg),
    .bcd_err  (bcd_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Seg value of a zero digit that leading-zero blanking would suppress.
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] ZB = 7'h7F;
`else
  localparam logic [6:0] ZB = 7'h40;
`endif

  typedef struct {
    logic [15:0] word;
    logic [6:0]  s0, s1, s2, s3;
    logic        err;
  } vec_t;

  vec_t tbl[7];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Observe one full frame (16 cycles) and check every slot.
  task automatic frame_chk(input vec_t v);
    logic [6:0] e[4];
    int on_cnt[4];
    int blanks;
    int d;
    e[0] = v.s0; e[1] = v.s1; e[2] = v.s2; e[3] = v.s3;
    for (int i = 0; i < 4; i++) on_cnt[i] = 0;
    blanks = 0;
    chk($sformatf("err_%04h", v.word), {31'd0, bcd_err}, {31'd0, v.err});
    for (int k = 0; k < 16; k++) begin
      d = -1;
      case (an)
        4'hE: d = 0;
        4'hD: d = 1;
        4'hB: d = 2;
        4'h7: d = 3;
        4'hF: d = 4;
        default: d = -1;
      endcase
      if (d < 0) begin
        chk($sformatf("an_legal_%04h", v.word), {28'd0, an}, 32'hF);
      end else if (d == 4) begin
        blanks++;
        chk($sformatf("blank_seg_%04h", v.word), {25'd0, seg}, 32'h7F);
      end else begin
        on_cnt[d]++;
        chk($sformatf("seg_%04h_d%0d", v.word, d), {25'd0, seg}, {25'd0, e[d]});
      end
      tick();
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("on_time_%04h_d%0d", v.word, i), on_cnt[i], 3);
    chk($sformatf("blank_count_%04h", v.word), blanks, 4);
  endtask

  task automatic capture(input logic [15:0] w);
    bcd_d_in = w;
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    tick();
  endtask

  logic [3:0] seq_an[8];
  logic [6:0] seq_seg[8];
  vec_t       v;
  bit         found;

  initial begin
    rst = 1'b1;
    rdy = 1'b0;
    bcd_d_in = 16'h0000;

    tbl[0] = '{16'h4095, 7'h12, 7'h10, 7'h40, 7'h19, 1'b0};
    tbl[1] = '{16'h00A3, 7'h30, 7'h3F, ZB,    ZB,    1'b1};
    tbl[2] = '{16'h0003, 7'h30, ZB,    ZB,    ZB,    1'b0};
    tbl[3] = '{16'h0007, 7'h78, ZB,    ZB,    ZB,    1'b0};
    tbl[4] = '{16'h1007, 7'h78, 7'h40, 7'h40, 7'h79, 1'b0};
    tbl[5] = '{16'h0000, 7'h40, ZB,    ZB,    ZB,    1'b0};
    tbl[6] = '{16'hF00C, 7'h3F, 7'h40, 7'h40, 7'h3F, 1'b1};

    // Reset held for three cycles: everything off.
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_an",  {28'd0, an},      32'hF);
      chk("rst_seg", {25'd0, seg},     32'h7F);
      chk("rst_err", {31'd0, bcd_err}, 32'h0);
    end
    rst = 1'b0;

    // First two slots after release, exact order.
    seq_an  = '{4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF};
    seq_seg = '{7'h40, 7'h40, 7'h40, 7'h7F, ZB, ZB, ZB, 7'h7F};
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("post_rst_an_%0d", k),  {28'd0, an},  {28'd0, seq_an[k]});
      chk($sformatf("post_rst_seg_%0d", k), {25'd0, seg}, {25'd0, seq_seg[k]});
    end

    // Table: single-pulse captures, each followed by a full frame.
    for (int i = 0; i < 7; i++) begin
      capture(tbl[i].word);
      frame_chk(tbl[i]);
    end

    // rdy held high 20 cycles; the word changes after the capture edge.
    bcd_d_in = 16'h1234;
    rdy = 1'b1;
    tick();
    bcd_d_in = 16'h5678;
    for (int k = 0; k < 19; k++) tick();
    rdy = 1'b0;
    tick();
    v = '{16'h1234, 7'h19, 7'h30, 7'h24, 7'h79, 1'b0};
    frame_chk(v);

    // Reset in the middle of the DIG2 slot after showing 9999.
    capture(16'h9999);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (an == 4'hB) found = 1'b1;
      else tick();
    end
    chk("find_dig2", {31'd0, found}, 32'h1);
    chk("dig2_seg_9999", {25'd0, seg}, 32'h10);
    rst = 1'b1;
    tick();
    chk("mid_rst_an",  {28'd0, an},      32'hF);
    chk("mid_rst_seg", {25'd0, seg},     32'h7F);
    chk("mid_rst_err", {31'd0, bcd_err}, 32'h0);
    rst = 1'b0;
    seq_an  = '{4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF};
    seq_seg = '{7'h40, 7'h40, 7'h40, 7'h7F, ZB, ZB, ZB, 7'h7F};
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("restart_an_%0d", k),  {28'd0, an},  {28'd0, seq_an[k]});
      chk($sformatf("restart_seg_%0d", k), {25'd0, seg}, {25'd0, seq_seg[k]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
